// File: rtl/float_multiply_iter.sv
// Multi-cycle IEEE-754 single-precision multiplier: one 48-bit adder iterated
// 24 times (shift-and-add), truncating result, start/done handshake.
module float_multiply_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] product,
   output logic        zero,
   output logic        overflow,
   output logic        underflow,
   output logic        exception
);

   typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [47:0]        r_acc;
   logic [23:0]        r_ma;
   logic [23:0]        r_mb;
   logic [4:0]         r_cnt;
   logic signed [9:0]  r_exp;
   logic               r_sign;
   logic               r_exc;
   logic               r_nan;
   logic               r_zin;

   logic signed [9:0]  w_exp_n;
   logic [22:0]        w_mant;
   logic [31:0]        w_prod;
   logic [3:0]         w_flags;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? MULT : IDLE;
         MULT:    w_next = (r_cnt == 5'd23) ? NORM : MULT;
         NORM:    w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Normalise, truncate and classify; special classes were latched at accept
   always_comb begin
      w_exp_n = r_exp;
      w_mant  = r_acc[45:23];
      w_prod  = 32'h0000_0000;
      w_flags = 4'b0000;
      if (r_acc[47]) begin
         w_exp_n = r_exp + 10'sd1;
         w_mant  = r_acc[46:24];
      end else begin
         w_exp_n = r_exp;
         w_mant  = r_acc[45:23];
      end
      if (r_exc) begin
         w_prod  = r_nan ? 32'h7FC0_0000 : {r_sign, 8'hFF, 23'd0};
         w_flags = 4'b1000;
      end else if (r_zin) begin
         w_prod  = 32'h0000_0000;
         w_flags = 4'b0100;
      end else if (w_exp_n >= 10'sd255) begin
         w_prod  = {r_sign, 8'hFF, 23'd0};
         w_flags = 4'b0010;
      end else if (w_exp_n <= 10'sd0) begin
         w_prod  = 32'h0000_0000;
         w_flags = 4'b0001;
      end else begin
         w_prod  = {r_sign, w_exp_n[7:0], w_mant};
         w_flags = 4'b0000;
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc     <= 48'd0;
         r_ma      <= 24'd0;
         r_mb      <= 24'd0;
         r_cnt     <= 5'd0;
         r_exp     <= 10'sd0;
         r_sign    <= 1'b0;
         r_exc     <= 1'b0;
         r_nan     <= 1'b0;
         r_zin     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         product   <= 32'h0000_0000;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         exception <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sign <= A[31] ^ B[31];
                  r_exp  <= $signed({2'b00, A[30:23]} + {2'b00, B[30:23]} - 10'd127);
                  r_ma   <= {1'b1, A[22:0]};
                  r_mb   <= {1'b1, B[22:0]};
                  r_acc  <= 48'd0;
                  r_cnt  <= 5'd0;
                  r_exc  <= (A[30:23] == 8'hFF) || (B[30:23] == 8'hFF);
                  r_nan  <= (A[30:23] == 8'h00) || (B[30:23] == 8'h00);
                  r_zin  <= (A[30:23] == 8'h00) || (B[30:23] == 8'h00);
                  busy   <= 1'b1;
               end
            end
            MULT: begin
               if (r_mb[0]) begin
                  r_acc <= r_acc + ({24'd0, r_ma} << r_cnt);
               end
               r_mb  <= r_mb >> 1;
               r_cnt <= (r_cnt == 5'd23) ? 5'd0 : r_cnt + 5'd1;
            end
            NORM: begin
               product   <= w_prod;
               exception <= w_flags[3];
               zero      <= w_flags[2];
               overflow  <= w_flags[1];
               underflow <= w_flags[0];
               done      <= 1'b1;
            end
            DONE: begin
               done <= 1'b0;
               busy <= 1'b0;
            end
            default: begin
               done <= 1'b0;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_float_multiply_iter.sv
// Directed bench for float_multiply_iter: expected results are queued when an
// operation is launched and popped when done pulses.
module tb_float_multiply_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [31:0] product;
   logic        zero;
   logic        overflow;
   logic        underflow;
   logic        exception;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] q_prod[$];
   logic [3:0]  q_flag[$];
   logic [31:0] a_arr[81];
   logic [31:0] b_arr[81];

   float_multiply_iter dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .product(product), .zero(zero),
      .overflow(overflow), .underflow(underflow), .exception(exception)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: full-width mantissa product, truncated; returns {flags, product}
   function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] ma, mb, m;
      logic [7:0]  ea, eb;
      logic [22:0] mant;
      logic        s;
      int          e;
      ea = a[30:23]; eb = b[30:23]; s = a[31] ^ b[31];
      ma = {24'd0, 1'b1, a[22:0]};
      mb = {24'd0, 1'b1, b[22:0]};
      m  = ma * mb;
      e  = int'(ea) + int'(eb) - 127;
      if (m[47]) begin mant = m[46:24]; e = e + 1; end
      else       mant = m[45:23];
      if (ea == 8'hFF || eb == 8'hFF)
         return {4'b1000, ((ea == 8'h00 || eb == 8'h00) ? 32'h7FC0_0000 : {s, 8'hFF, 23'd0})};
      else if (ea == 8'h00 || eb == 8'h00) return {4'b0100, 32'h0};
      else if (e >= 255) return {4'b0010, s, 8'hFF, 23'd0};
      else if (e <= 0)   return {4'b0001, 32'h0};
      else begin
         logic [31:0] ev;
         ev = e;
         return {4'b0000, s, ev[7:0], mant};
      end
   endfunction

   task automatic pop_cmp(input string tag);
      if (q_prod.size() > 0) begin
         chk({tag, "_product"}, product, q_prod.pop_front());
         chk({tag, "_flags"}, {28'd0, exception, zero, overflow, underflow}, {28'd0, q_flag.pop_front()});
      end else begin
         chk({tag, "_unexpected_done"}, 32'd1, 32'd0);
      end
   endtask

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ep,
                        input logic [3:0] ef, input string tag, input bit pulse);
      int n;
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      q_prod.push_back(ep); q_flag.push_back(ef);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; A = ~a; B = ~b;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      n = 0;
      while (!done && n < 40) begin
         if (pulse && n == 5) begin start = 1'b1; A = 32'h3F80_0000; B = 32'h3F80_0000; end
         else start = 1'b0;
         @(posedge clk); n++;
         @(negedge clk);
      end
      start = 1'b0;
      // done is first visible after edge E25 (edges E0..E25 inclusive = 26)
      chk({tag, "_latency"}, n, 32'd25);
      pop_cmp(tag);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_busy_low"}, {30'd0, busy, done}, 32'd0);
      chk({tag, "_held"}, product, ep);
   endtask

   initial begin
      logic [35:0] m;
      logic [31:0] r;
      int dn;
      int seen;
      rst = 1'b1; start = 1'b0; A = 32'h0; B = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {25'd0, busy, done, exception, zero, overflow, underflow, 1'b0}, 32'd0);
      chk("reset_product", product, 32'h0);
      rst = 1'b0;

      do_op(32'h4040_0000, 32'h4020_0000, 32'h40F0_0000, 4'b0000, "3x2.5", 1'b0);
      do_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, "1.5sq", 1'b0);
      do_op(32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 4'b0000, "neg", 1'b0);
      do_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, "one", 1'b0);
      do_op(32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 4'b0100, "zero", 1'b0);
      do_op(32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 4'b1000, "inf", 1'b0);
      do_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, "nan", 1'b0);
      do_op(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0010, "ovf", 1'b0);
      do_op(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 4'b0001, "unf", 1'b0);
      do_op(32'h4040_0000, 32'hC020_0000, 32'hC0F0_0000, 4'b0000, "pulse", 1'b1);

      // start held high with operands changing every cycle
      for (int i = 0; i < 81; i++) begin
         r = $urandom;
         a_arr[i] = {r[31], 8'd100 + {3'b000, r[27:23]}, r[22:0]};
         r = $urandom;
         b_arr[i] = {r[31], 8'd100 + {3'b000, r[27:23]}, r[22:0]};
      end
      for (int i = 0; i < 3; i++) begin
         m = model(a_arr[27*i], b_arr[27*i]);
         q_prod.push_back(m[31:0]); q_flag.push_back(m[35:32]);
      end
      dn = 0;
      for (int k = 0; k < 81; k++) begin
         A = a_arr[k]; B = b_arr[k]; start = 1'b1;
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            chk("hold_done_cycle", k, 25 + 27 * dn);
            pop_cmp("hold");
            dn++;
         end
      end
      start = 1'b0;
      chk("hold_done_count", dn, 32'd3);

      // reset in the middle of an operation
      @(negedge clk);
      A = 32'h4040_0000; B = 32'h4020_0000; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_outs", {25'd0, busy, done, exception, zero, overflow, underflow, 1'b0}, 32'd0);
      chk("midrst_product", product, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (done || busy) seen++;
      end
      chk("midrst_no_done", seen, 32'd0);
      do_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, "after_rst", 1'b0);

      chk("queue_empty", q_prod.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
